// File: rtl/tap_capture_fifo_pkg.sv
// Shared definitions for the tap delay line and its capture FIFO.
// Sample width, tap depth and tap-index type must agree with the delay-line block.
package tap_capture_fifo_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TAP_LAST   = 3;

  typedef logic [1:0] tap_idx_t;

  // A tap holds post-reset data once that many stages have been filled.
  function automatic logic tap_primed(input int fill, input int idx);
    return idx <= fill;
  endfunction

endpackage

// File: rtl/tap_capture_fifo_core.sv
// First-word-fall-through FIFO: head word is visible on rd_data whenever count != 0.
// push/pop must already be qualified by the caller (no push when full without pop).
module tap_fifo_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

endmodule

// File: rtl/tap_capture_fifo.sv
// Captures primed delay-line taps into a FWFT FIFO and offers them over valid/ready.
// Holds the stage fill counter, the push qualification and the sticky overflow flag.
module tap_capture_fifo
  import tap_capture_fifo_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter int DEPTH   = FIFO_DEPTH,
  parameter int TAP_MAX = TAP_LAST
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cap_en,
  input  tap_idx_t               sel,
  input  logic [WIDTH-1:0]       tap_q,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int FILL_W = $clog2(TAP_MAX + 1);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic [FILL_W-1:0] r_fill;
  logic              r_overflow;
  logic              w_primed;
  logic              w_pop;
  logic              w_full;
  logic              w_push;
  logic              w_drop;
  logic [CNT_W-1:0]  w_count;

  assign w_primed = tap_primed(int'(r_fill), int'(sel));
  assign w_pop    = out_valid & out_ready;
  assign w_full   = (w_count == CNT_W'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push   = cap_en & w_primed & (~w_full | w_pop);
  assign w_drop   = cap_en & w_primed & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (r_fill != FILL_W'(TAP_MAX)) begin
        r_fill <= r_fill + FILL_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  tap_fifo_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push),
    .pop     (w_pop),
    .wr_data (tap_q),
    .rd_data (out_data),
    .count   (w_count)
  );

  assign count     = w_count;
  assign out_valid = (w_count != '0);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_tap_capture_fifo.sv
// Directed and randomised checks of tap priming, FWFT ordering, full/pop and overflow.
module tb_tap_capture_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       cap_en;
  logic [1:0] sel;
  logic [7:0] tap_q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       overflow;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tap_capture_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .cap_en    (cap_en),
    .sel       (sel),
    .tap_q     (tap_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cap_en = 1'b0; out_ready = 1'b0; sel = 2'd0; tap_q = 8'h00;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_prime();
    do_reset();
    sel = 2'd3; cap_en = 1'b1; tap_q = 8'hA5;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_total++; if (count !== 3'd0) $display("FAIL prime_refuse cyc %0d count got %0d want 0", i, count); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL prime_ovf cyc %0d got %b want 0", i, overflow); else n_pass++;
    end
    step();
    cap_en = 1'b0;
    n_total++; if (out_valid !== 1'b1) $display("FAIL prime_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_data !== 8'hA5) $display("FAIL prime_data got %h want a5", out_data); else n_pass++;
    n_total++; if (count !== 3'd1) $display("FAIL prime_count got %0d want 1", count); else n_pass++;
    $display("test_prime done");
  endtask

  task automatic test_overflow();
    do_reset();
    sel = 2'd0; cap_en = 1'b1; out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tap_q = 8'(i);
      step();
    end
    n_total++; if (count !== 3'd4) $display("FAIL ovf_count4 got %0d want 4", count); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL ovf_early got %b want 0", overflow); else n_pass++;
    tap_q = 8'h05;
    step();
    cap_en = 1'b0;
    n_total++; if (count !== 3'd4) $display("FAIL ovf_count5 got %0d want 4", count); else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow); else n_pass++;
    n_total++; if (out_data !== 8'h01) $display("FAIL ovf_head got %h want 01", out_data); else n_pass++;
    step();
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else n_pass++;
    $display("test_overflow done");
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_vals [4];
    exp_vals[0] = 8'h21; exp_vals[1] = 8'h22; exp_vals[2] = 8'h23; exp_vals[3] = 8'h10;
    do_reset();
    sel = 2'd0; cap_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tap_q = 8'h20 + 8'(i);
      step();
    end
    n_total++; if (count !== 3'd4) $display("FAIL fullpop_fill got %0d want 4", count); else n_pass++;
    out_ready = 1'b1; tap_q = 8'h10;
    step();
    cap_en = 1'b0;
    n_total++; if (count !== 3'd4) $display("FAIL fullpop_count got %0d want 4", count); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf got %b want 0", overflow); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (out_valid !== 1'b1) $display("FAIL fullpop_valid %0d got %b want 1", i, out_valid); else n_pass++;
      n_total++; if (out_data !== exp_vals[i]) $display("FAIL fullpop_data %0d got %h want %h", i, out_data, exp_vals[i]); else n_pass++;
      step();
    end
    n_total++; if (count !== 3'd0) $display("FAIL fullpop_drained got %0d want 0", count); else n_pass++;
    $display("test_full_pop done");
  endtask

  task automatic test_stream();
    logic [7:0] q [$];
    int  sent = 0;
    int  rcvd = 0;
    logic do_pop;
    do_reset();
    sel = 2'd0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (sent >= 12 && q.size() == 0) break;
      out_ready = (cyc % 2 == 0);
      do_pop = (q.size() > 0) && out_ready;
      cap_en = (sent < 12) && ((q.size() < 4) || do_pop);
      tap_q  = 8'h30 + 8'(sent);
      n_total++; if (int'(count) != q.size()) $display("FAIL stream_count cyc %0d got %0d want %0d", cyc, count, q.size()); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL stream_ovf cyc %0d got %b want 0", cyc, overflow); else n_pass++;
      if (do_pop) begin
        n_total++;
        if (out_data !== 8'h30 + 8'(rcvd)) $display("FAIL stream_order cyc %0d got %h want %h", cyc, out_data, 8'h30 + 8'(rcvd));
        else n_pass++;
        rcvd++;
        void'(q.pop_front());
      end
      if (cap_en) begin
        q.push_back(tap_q);
        sent++;
      end
      step();
    end
    cap_en = 1'b0; out_ready = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL stream_end_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (rcvd != 12) $display("FAIL stream_received got %0d want 12", rcvd); else n_pass++;
    $display("test_stream done");
  endtask

  task automatic test_mid_reset();
    do_reset();
    sel = 2'd0; cap_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tap_q = 8'h40 + 8'(i);
      step();
    end
    n_total++; if (count !== 3'd3) $display("FAIL midrst_pre got %0d want 3", count); else n_pass++;
    do_reset();
    n_total++; if (count !== 3'd0) $display("FAIL midrst_count got %0d want 0", count); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid); else n_pass++;
    sel = 2'd2; cap_en = 1'b1; tap_q = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      step();
      n_total++; if (count !== 3'd0) $display("FAIL midrst_refuse edge %0d got %0d want 0", i, count); else n_pass++;
    end
    step();
    cap_en = 1'b0;
    n_total++; if (count !== 3'd1) $display("FAIL midrst_accept got %0d want 1", count); else n_pass++;
    n_total++; if (out_data !== 8'h5A) $display("FAIL midrst_data got %h want 5a", out_data); else n_pass++;
    $display("test_mid_reset done");
  endtask

  task automatic test_random();
    logic [7:0] mq [$];
    int   m_fill = 0;
    logic m_ovf  = 1'b0;
    logic m_pop, m_push, m_primed, m_full;
    int   errs_before;
    do_reset();
    errs_before = n_total - n_pass;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      n_total++; if (int'(count) != mq.size()) $display("FAIL rand_count cyc %0d got %0d want %0d", cyc, count, mq.size()); else n_pass++;
      n_total++; if (out_valid !== (mq.size() > 0)) $display("FAIL rand_valid cyc %0d got %b want %b", cyc, out_valid, mq.size() > 0); else n_pass++;
      n_total++; if (overflow !== m_ovf) $display("FAIL rand_ovf cyc %0d got %b want %b", cyc, overflow, m_ovf); else n_pass++;
      if (mq.size() > 0) begin
        n_total++; if (out_data !== mq[0]) $display("FAIL rand_data cyc %0d got %h want %h", cyc, out_data, mq[0]); else n_pass++;
      end
      reset     = ($urandom_range(0, 249) == 0);
      cap_en    = $urandom_range(0, 3) != 0;
      sel       = 2'($urandom_range(0, 3));
      out_ready = $urandom_range(0, 2) == 0;
      tap_q     = 8'($urandom);
      if (reset) begin
        mq.delete(); m_fill = 0; m_ovf = 1'b0;
      end else begin
        m_primed = (int'(sel) <= m_fill);
        m_pop    = (mq.size() > 0) && out_ready;
        m_full   = (mq.size() == 4);
        m_push   = cap_en && m_primed && (!m_full || m_pop);
        if (cap_en && m_primed && m_full && !m_pop) m_ovf = 1'b1;
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(tap_q);
        if (m_fill < 3) m_fill++;
      end
      step();
    end
    reset = 1'b0; cap_en = 1'b0; out_ready = 1'b0;
    $display("test_random done, %0d new failures", (n_total - n_pass) - errs_before);
  endtask

  initial begin
    reset = 1'b1; cap_en = 1'b0; sel = 2'd0; tap_q = 8'h00; out_ready = 1'b0;
    test_reset();
    test_prime();
    test_overflow();
    test_full_pop();
    test_stream();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
